// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: word-addressed RAM behind a request/busy
// handshake with LATENCY wait states, completing each access with an ack pulse.
module dm_responder #(
  parameter int NADDR   = 7,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [NADDR-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             busy,
  output logic             ack,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             err
);

  localparam int         DEPTH    = 1 << NADDR;
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;

  logic             r_op_rd;
  logic             r_op_wr;
  logic [NADDR-1:0] r_addr;
  logic [31:0]      r_wdata;

  logic             r_ack;
  logic             r_rsp_valid;
  logic             r_err;
  logic [31:0]      r_rdata;

  logic [31:0]      r_mem [0:DEPTH-1];

  logic             w_req;
  logic             w_capture;
  logic             w_access;
  logic             w_acc_rd;
  logic             w_acc_wr;
  logic [NADDR-1:0] w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic             w_do_load;
  logic             w_do_store;

  // Next-state and access-edge decode
  always_comb begin
    w_req       = req_rd | req_wr;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_capture = 1'b1;
          if (ZERO_LAT) begin
            w_access = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Zero-latency accesses happen at the acceptance edge, so they bypass the capture registers.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_rd    = req_rd;
      w_acc_wr    = req_wr;
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
    end else begin
      w_acc_rd    = r_op_rd;
      w_acc_wr    = r_op_wr;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    w_do_load  = w_access & w_acc_rd & ~w_acc_wr;
    w_do_store = w_access & w_acc_wr & ~w_acc_rd & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_rd     <= 1'b0;
      r_op_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ack       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_op_rd <= req_rd;
        r_op_wr <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_ack       <= w_access;
      r_rsp_valid <= w_do_load;
      r_err       <= w_access & w_acc_rd & w_acc_wr;
      if (w_do_load) begin
        r_rdata <= r_mem[w_acc_addr];
      end
    end
  end

  // RAM contents survive reset; the store enable is gated by rst_n instead.
  always_ff @(posedge clk) begin
    if (w_do_store) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

  always_comb begin
    busy      = rst_n & (((r_state == S_IDLE) & w_req & ~ZERO_LAT) | (r_state == S_WAIT));
    ack       = r_ack;
    rsp_valid = r_rsp_valid;
    err       = r_err;
    rsp_rdata = r_rdata;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: six instances with latencies 0,1,2,3,4,15 checked
// cycle by cycle against a transaction-level memory/timing model.
module tb_dm_responder;

  localparam int NI = 6;

  function automatic int lat_of(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 4;
      default: return 15;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] rd_i;
  logic [NI-1:0] wr_i;
  logic [6:0]    addr_i  [NI];
  logic [31:0]   wdata_i [NI];
  logic [NI-1:0] busy_o;
  logic [NI-1:0] ack_o;
  logic [NI-1:0] vld_o;
  logic [NI-1:0] err_o;
  logic [31:0]   rdata_o [NI];

  logic [31:0]   mem_m [NI][128];
  logic [31:0]   exp_rd [NI];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dm_responder #(.NADDR(7), .LATENCY(lat_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_rd    (rd_i[g]),
      .req_wr    (wr_i[g]),
      .req_addr  (addr_i[g]),
      .req_wdata (wdata_i[g]),
      .busy      (busy_o[g]),
      .ack       (ack_o[g]),
      .rsp_valid (vld_o[g]),
      .rsp_rdata (rdata_o[g]),
      .err       (err_o[g])
    );
  end

  // One full transaction from presentation to its ack cycle; returns at the
  // negedge of the ack cycle with the request withdrawn.
  task automatic access(input int k, input bit rd, input bit wr,
                        input logic [6:0] a, input logic [31:0] d);
    int lat;
    lat = lat_of(k);
    rd_i[k] = rd; wr_i[k] = wr; addr_i[k] = a; wdata_i[k] = d;
    #1;
    n_cmp++;
    if (busy_o[k] !== (lat != 0)) begin
      n_bad++;
      $display("FAIL busy_present k=%0d got %b want %b", k, busy_o[k], lat != 0);
    end
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      if (j == lat + 1) begin
        if (wr && !rd) mem_m[k][a] = d;
        if (rd && !wr) exp_rd[k] = mem_m[k][a];
      end
      n_cmp++;
      if (busy_o[k] !== (j <= lat)) begin
        n_bad++;
        $display("FAIL busy k=%0d j=%0d got %b want %b", k, j, busy_o[k], j <= lat);
      end
      n_cmp++;
      if (ack_o[k] !== (j == lat + 1)) begin
        n_bad++;
        $display("FAIL ack k=%0d j=%0d got %b want %b", k, j, ack_o[k], j == lat + 1);
      end
      n_cmp++;
      if (vld_o[k] !== (j == lat + 1 && rd && !wr)) begin
        n_bad++;
        $display("FAIL rsp_valid k=%0d j=%0d got %b want %b", k, j, vld_o[k],
                 j == lat + 1 && rd && !wr);
      end
      n_cmp++;
      if (err_o[k] !== (j == lat + 1 && rd && wr)) begin
        n_bad++;
        $display("FAIL err k=%0d j=%0d got %b want %b", k, j, err_o[k], j == lat + 1 && rd && wr);
      end
      n_cmp++;
      if (rdata_o[k] !== exp_rd[k]) begin
        n_bad++;
        $display("FAIL rsp_rdata k=%0d j=%0d got %h want %h", k, j, rdata_o[k], exp_rd[k]);
      end
    end
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      exp_rd[k] = '0;
      n_cmp++;
      if ({busy_o[k], ack_o[k], vld_o[k], err_o[k]} !== 4'b0000 || rdata_o[k] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_state k=%0d got b%b a%b v%b e%b d%h want 0", k,
                 busy_o[k], ack_o[k], vld_o[k], err_o[k], rdata_o[k]);
      end
    end
    wr_i[2] = 1'b1; addr_i[2] = 7'd3; wdata_i[2] = 32'h1234_5678;
    #1;
    n_cmp++;
    if (busy_o[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_in_reset got %b want 0", busy_o[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(2, 1'b0, 1'b1, 7'd3, 32'h1234_5678);
  endtask

  task automatic test_fill();
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 128; a++) begin
        access(k, 1'b0, 1'b1, 7'(a), $urandom);
        if (lat_of(k) != 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_store_load_l2();
    access(2, 1'b0, 1'b1, 7'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    access(2, 1'b1, 1'b0, 7'd5, 32'h0);
    n_cmp++;
    if (rdata_o[2] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL l2_load got %h want deadbeef", rdata_o[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    access(0, 1'b0, 1'b1, 7'd1, 32'h11);
    access(0, 1'b0, 1'b1, 7'd2, 32'h22);
    access(0, 1'b1, 1'b0, 7'd1, 32'h0);
    n_cmp++;
    if (rdata_o[0] !== 32'h11) begin
      n_bad++;
      $display("FAIL b2b_first got %h want 11", rdata_o[0]);
    end
    access(0, 1'b1, 1'b0, 7'd2, 32'h0);
    n_cmp++;
    if (rdata_o[0] !== 32'h22) begin
      n_bad++;
      $display("FAIL b2b_second got %h want 22", rdata_o[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_dual();
    access(3, 1'b0, 1'b1, 7'd7, 32'h5);
    @(negedge clk);
    access(3, 1'b1, 1'b0, 7'd8, 32'h0);
    @(negedge clk);
    access(3, 1'b1, 1'b1, 7'd7, 32'hFFFF_FFFF);
    @(negedge clk);
    access(3, 1'b1, 1'b0, 7'd7, 32'h0);
    n_cmp++;
    if (rdata_o[3] !== 32'h5) begin
      n_bad++;
      $display("FAIL dual_followup got %h want 5", rdata_o[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    access(4, 1'b0, 1'b1, 7'd9, 32'h1);
    @(negedge clk);
    wr_i[4] = 1'b1; addr_i[4] = 7'd9; wdata_i[4] = 32'hAAAA;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy_o[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_before_abort got %b want 1", busy_o[4]);
    end
    rst_n = 1'b0; wr_i[4] = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_rd[k] = '0;
      n_cmp++;
      if ({busy_o[k], ack_o[k], vld_o[k], err_o[k]} !== 4'b0000 || rdata_o[k] !== 32'h0) begin
        n_bad++;
        $display("FAIL abort_state k=%0d got b%b a%b v%b e%b d%h want 0", k,
                 busy_o[k], ack_o[k], vld_o[k], err_o[k], rdata_o[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      n_cmp++;
      if (ack_o[4] !== 1'b0 || busy_o[4] !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_ack j=%0d got a%b b%b want 0 0", j, ack_o[4], busy_o[4]);
      end
    end
    access(4, 1'b1, 1'b0, 7'd9, 32'h0);
    n_cmp++;
    if (rdata_o[4] !== 32'h1) begin
      n_bad++;
      $display("FAIL abort_ram got %h want 1", rdata_o[4]);
    end
    @(negedge clk);
  endtask

  task automatic test_input_change();
    logic [31:0] da, db;
    da = $urandom; db = $urandom;
    wr_i[1] = 1'b1; rd_i[1] = 1'b0; addr_i[1] = 7'd20; wdata_i[1] = da;
    @(negedge clk);
    addr_i[1] = 7'd21; wdata_i[1] = db;
    @(negedge clk);
    mem_m[1][20] = da;
    n_cmp++;
    if (ack_o[1] !== 1'b1 || busy_o[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL chg_done got a%b b%b want 1 0", ack_o[1], busy_o[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (ack_o[1] !== 1'b0 || busy_o[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL chg_reaccept got a%b b%b want 0 1", ack_o[1], busy_o[1]);
    end
    @(negedge clk);
    @(negedge clk);
    mem_m[1][21] = db;
    n_cmp++;
    if (ack_o[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL chg_second_ack got %b want 1", ack_o[1]);
    end
    wr_i[1] = 1'b0;
    @(negedge clk);
    access(1, 1'b1, 1'b0, 7'd20, 32'h0);
    n_cmp++;
    if (rdata_o[1] !== da) begin
      n_bad++;
      $display("FAIL chg_addr20 got %h want %h", rdata_o[1], da);
    end
    @(negedge clk);
    access(1, 1'b1, 1'b0, 7'd21, 32'h0);
    n_cmp++;
    if (rdata_o[1] !== db) begin
      n_bad++;
      $display("FAIL chg_addr21 got %h want %h", rdata_o[1], db);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_l15();
    logic [31:0] dv;
    dv = $urandom | 32'h1;
    access(5, 1'b0, 1'b1, 7'd0, 32'h0);
    @(negedge clk);
    access(5, 1'b0, 1'b1, 7'd127, dv);
    @(negedge clk);
    access(5, 1'b1, 1'b0, 7'd0, 32'h0);
    n_cmp++;
    if (rdata_o[5] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_addr0 got %h want 0", rdata_o[5]);
    end
    @(negedge clk);
    access(5, 1'b1, 1'b0, 7'd127, 32'h0);
    n_cmp++;
    if (rdata_o[5] !== dv) begin
      n_bad++;
      $display("FAIL wrap_addr127 got %h want %h", rdata_o[5], dv);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int sel;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 40; n++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)
          access(k, 1'b1, 1'b1, 7'($urandom_range(0, 15)), $urandom);
        else if (sel < 5)
          access(k, 1'b0, 1'b1, 7'($urandom_range(0, 15)), $urandom);
        else
          access(k, 1'b1, 1'b0, 7'($urandom_range(0, 15)), $urandom);
        if (lat_of(k) != 0) @(negedge clk);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rd_i = '0;
    wr_i = '0;
    for (int k = 0; k < NI; k++) begin
      addr_i[k]  = '0;
      wdata_i[k] = '0;
      exp_rd[k]  = '0;
    end
    test_reset();
    test_fill();
    test_store_load_l2();
    test_back_to_back();
    test_dual();
    test_reset_mid();
    test_input_change();
    test_wrap_l15();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
